// File: rtl/fetch_pc_sequencer_pkg.sv
// rtl/fetch_pc_sequencer_pkg.sv - shared opcode/func constants, sequencer states and immediate helper
package fetch_pc_sequencer_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BGEZ    = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [5:0] FN_TRAPBR  = 6'b110100;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } seq_state_e;

    // Word-offset branch displacement: sign-extended imm16 scaled to bytes.
    function automatic logic [31:0] branch_disp(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_sequencer_if.sv
// rtl/fetch_pc_sequencer_if.sv - instruction-memory fetch bus between sequencer and imem
interface fetch_pc_sequencer_if;

    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_pc_sequencer_branch_target_calc.sv
// rtl/fetch_pc_sequencer_branch_target_calc.sv - combinational redirect target mux for ID-stage branches/jumps
module branch_target_calc
    import fetch_pc_sequencer_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC = 32'h0040_0004
) (
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic [15:0] imm16,
    input  logic [25:0] index26,
    input  logic [31:0] pc,
    input  logic [31:0] rs_val,
    output logic [31:0] target
);

    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        // Non-control opcodes never assert branch, so their value is irrelevant.
        target = pc_plus4;
        case (op)
            OP_BEQ, OP_BNE, OP_BGEZ: target = pc_plus4 + branch_disp(imm16);
            OP_J, OP_JAL:            target = {pc_plus4[31:28], index26, 2'b00};
            OP_SPECIAL: begin
                if (func == FN_JR || func == FN_JALR) begin
                    target = rs_val;
                end else if (func == FN_TRAPBR) begin
                    target = TRAP_VEC;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// rtl/fetch_pc_sequencer.sv - IF-stage PC sequencer driving imem and the IF/ID payload
// Optional DELAY_SLOT_EN: keep the word in IF at a redirect and suppress flush_ifid.
module fetch_pc_sequencer
    import fetch_pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0040_0004
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         branch,
    input  logic [5:0]                   id_op,
    input  logic [5:0]                   id_func,
    input  logic [15:0]                  id_imm16,
    input  logic [25:0]                  id_index26,
    input  logic [31:0]                  id_pc,
    input  logic [31:0]                  id_rs_reg,
    fetch_pc_sequencer_if.master         imem,
    output logic [31:0]                  if_pc,
    output logic [31:0]                  if_instr,
    output logic                         if_valid,
    output logic                         flush_ifid
);

`ifdef DELAY_SLOT_EN
    localparam bit KEEP_SLOT = 1'b1;
`else
    localparam bit KEEP_SLOT = 1'b0;
`endif

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;
    logic        flush_q, flush_d;
    logic [31:0] hold_word_q, hold_word_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pend_valid_q, pend_valid_d;

    logic [31:0] target;
    logic        redirect;

    branch_target_calc #(
        .TRAP_VEC (TRAP_VEC)
    ) u_target (
        .op      (id_op),
        .func    (id_func),
        .imm16   (id_imm16),
        .index26 (id_index26),
        .pc      (id_pc),
        .rs_val  (id_rs_reg),
        .target  (target)
    );

    assign redirect = branch && !stall;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        if_valid_d    = if_valid_q;
        flush_d       = 1'b0;
        hold_word_d   = hold_word_q;
        pend_target_d = pend_target_q;
        pend_valid_d  = pend_valid_q;

        case (state_q)
            BOOT: begin
                if (!stall) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (redirect) begin
                    flush_d    = !KEEP_SLOT;
                    if_valid_d = 1'b0;
                    if (imem.imem_ready) begin
                        pc_d = target;
                        if (KEEP_SLOT) begin
                            if_instr_d = imem.imem_rdata;
                            if_pc_d    = pc_q;
                            if_valid_d = 1'b1;
                        end
                    end else begin
                        // imem_addr must stay put until the outstanding fetch returns.
                        state_d       = DRAIN;
                        pend_target_d = target;
                        pend_valid_d  = 1'b1;
                    end
                end else if (stall) begin
                    if (imem.imem_ready) begin
                        hold_word_d = imem.imem_rdata;
                        state_d     = HOLD;
                    end
                end else if (imem.imem_ready) begin
                    if_instr_d = imem.imem_rdata;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + 32'd4;
                end else begin
                    if_valid_d = 1'b0;
                end
            end

            HOLD: begin
                if (!stall) begin
                    state_d    = FETCH;
                    if_instr_d = hold_word_q;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    if (branch) begin
                        pc_d       = target;
                        flush_d    = !KEEP_SLOT;
                        if_valid_d = KEEP_SLOT;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end

            DRAIN: begin
                if (!stall) begin
                    if_valid_d = 1'b0;
                    if (redirect) begin
                        flush_d       = !KEEP_SLOT;
                        pend_target_d = target;
                    end
                    if (imem.imem_ready) begin
                        state_d      = FETCH;
                        pend_valid_d = 1'b0;
                        pc_d         = redirect ? target : pend_target_q;
                        if (KEEP_SLOT) begin
                            if_instr_d = imem.imem_rdata;
                            if_pc_d    = pc_q;
                            if_valid_d = 1'b1;
                        end
                    end
                end
            end

            default: state_d = BOOT;
        endcase

        req_d = (state_d == FETCH) || (state_d == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            req_q         <= 1'b0;
            if_pc_q       <= 32'd0;
            if_instr_q    <= 32'd0;
            if_valid_q    <= 1'b0;
            flush_q       <= 1'b0;
            hold_word_q   <= 32'd0;
            pend_target_q <= 32'd0;
            pend_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_q         <= req_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            if_valid_q    <= if_valid_d;
            flush_q       <= flush_d;
            hold_word_q   <= hold_word_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign imem.imem_req  = req_q;
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;
    assign if_valid       = if_valid_q;
    assign flush_ifid     = flush_q;

endmodule
